// File: rtl/sig_transmitter_pkg.sv
// Shared types and constants for the spread-code signal transmitter.
package sig_transmitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam int   PREAMBLE_SYMBOLS = 4;
  localparam int   DATA_BITS        = 8;
  localparam logic PERIOD_6         = 1'b0;
  localparam logic PERIOD_8         = 1'b1;

  // Reduce a 3-bit phase into the range of the selected code period.
  function automatic logic [2:0] phase_mod(input logic period_sel, input logic [2:0] phase);
    logic [2:0] r;
    r = phase;
    if (period_sel == PERIOD_6 && phase >= 3'd6) begin
      r = phase - 3'd6;
    end
    return r;
  endfunction

endpackage

// File: rtl/sig_transmitter_code_chip_gen.sv
// Base chip generator: chip is high for the first half of the shifted period.
module code_chip_gen
  import sig_transmitter_pkg::*;
(
  input  logic       period_sel_i,
  input  logic [2:0] phase_i,
  input  logic [2:0] chip_i,
  output logic       chip_b_o
);

  logic [3:0] period;
  logic [3:0] half;
  logic [3:0] sum;
  logic [3:0] wrapped;

  // (chip + phase) mod P compared against P/2; phase is already < P.
  always_comb begin
    period   = (period_sel_i == PERIOD_8) ? 4'd8 : 4'd6;
    half     = period >> 1;
    sum      = {1'b0, chip_i} + {1'b0, phase_i};
    wrapped  = (sum >= period) ? (sum - period) : sum;
    chip_b_o = (wrapped < half);
  end

endmodule

// File: rtl/sig_transmitter.sv
// Frame sequencer: preamble of ones, LSB-first data byte, optional idle gap,
// each symbol spread over a P-chip code with CHIP_CLKS cycles per chip.
module sig_transmitter
  import sig_transmitter_pkg::*;
#(
  parameter int unsigned CHIP_CLKS   = 1,
  parameter int unsigned GAP_SYMBOLS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  input  logic       period_sel,
  input  logic [2:0] phase,
  output logic       sig,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] CHIP_LAST = 8'(CHIP_CLKS - 1);
  localparam logic [3:0] GAP_LAST  = (GAP_SYMBOLS == 0) ? 4'd0 : 4'(GAP_SYMBOLS - 1);
  localparam logic [3:0] PRE_LAST  = 4'(PREAMBLE_SYMBOLS - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  state_t     state_q, state_d;
  logic [7:0] clk_cnt_q, clk_cnt_d;
  logic [2:0] chip_q, chip_d;
  logic [3:0] sym_q, sym_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic       period_q, period_d;
  logic [2:0] phase_q, phase_d;
  logic       sig_q, sig_d;

  logic [2:0] chip_last;
  logic       chip_end;
  logic       sym_end;
  logic       accept;
  logic       chip_b;

  assign ready  = (state_q == ST_IDLE) && !rst;
  assign busy   = (state_q != ST_IDLE);
  assign sig    = sig_q;
  assign accept = valid && ready;

  // Next-state for the FSM, the chip/symbol/bit counters and the frame latches.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    chip_d    = chip_q;
    sym_d     = sym_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    period_d  = period_q;
    phase_d   = phase_q;

    chip_last = (period_q == PERIOD_8) ? 3'd7 : 3'd5;
    chip_end  = (clk_cnt_q == CHIP_LAST);
    sym_end   = chip_end && (chip_q == chip_last);

    if (state_q == ST_IDLE) begin
      if (accept) begin
        byte_d    = data_in;
        period_d  = period_sel;
        phase_d   = phase_mod(period_sel, phase);
        state_d   = ST_PREAMBLE;
        clk_cnt_d = 8'd0;
        chip_d    = 3'd0;
        sym_d     = 4'd0;
        bit_d     = 3'd0;
      end
    end else begin
      if (chip_end) begin
        clk_cnt_d = 8'd0;
        chip_d    = sym_end ? 3'd0 : chip_q + 3'd1;
      end else begin
        clk_cnt_d = clk_cnt_q + 8'd1;
      end

      if (sym_end) begin
        case (state_q)
          ST_PREAMBLE: begin
            if (sym_q == PRE_LAST) begin
              state_d = ST_DATA;
              sym_d   = 4'd0;
              bit_d   = 3'd0;
            end else begin
              sym_d = sym_q + 4'd1;
            end
          end
          ST_DATA: begin
            if (bit_q == BIT_LAST) begin
              bit_d   = 3'd0;
              sym_d   = 4'd0;
              state_d = (GAP_SYMBOLS == 0) ? ST_IDLE : ST_GAP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          ST_GAP: begin
            if (sym_q == GAP_LAST) begin
              sym_d   = 4'd0;
              state_d = ST_IDLE;
            end else begin
              sym_d = sym_q + 4'd1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Final cycle of the frame; suppressed while reset is asserted.
  always_comb begin
    frame_done = 1'b0;
    if (!rst && sym_end) begin
      if (state_q == ST_DATA && bit_q == BIT_LAST && GAP_SYMBOLS == 0) begin
        frame_done = 1'b1;
      end
      if (state_q == ST_GAP && sym_q == GAP_LAST) begin
        frame_done = 1'b1;
      end
    end
  end

  // Chip for the upcoming cycle, so the registered line leads with chip 0 right after accept.
  code_chip_gen u_chip_gen (
    .period_sel_i (period_d),
    .phase_i      (phase_d),
    .chip_i       (chip_d),
    .chip_b_o     (chip_b)
  );

  // Map the upcoming state and symbol bit onto the line value.
  always_comb begin
    sig_d = 1'b0;
    case (state_d)
      ST_PREAMBLE: sig_d = chip_b;
      ST_DATA:     sig_d = byte_d[bit_d] ? chip_b : !chip_b;
      default:     sig_d = 1'b0;
    endcase
  end

  // State, counters, latches and the output line register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= 8'd0;
      chip_q    <= 3'd0;
      sym_q     <= 4'd0;
      bit_q     <= 3'd0;
      byte_q    <= 8'd0;
      period_q  <= 1'b0;
      phase_q   <= 3'd0;
      sig_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      chip_q    <= chip_d;
      sym_q     <= sym_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      period_q  <= period_d;
      phase_q   <= phase_d;
      sig_q     <= sig_d;
    end
  end

endmodule

// File: tb/tb_sig_transmitter.sv
// Directed bench with an expected-output queue for two transmitter configurations.
module tb_sig_transmitter;

  localparam int CLK_A = 1;
  localparam int GAP_A = 1;
  localparam int CLK_B = 3;
  localparam int GAP_B = 0;

  logic       clk = 1'b0;
  logic       rst        [2];
  logic [7:0] data_in    [2];
  logic       valid      [2];
  logic       ready      [2];
  logic       period_sel [2];
  logic [2:0] phase      [2];
  logic       sig        [2];
  logic       busy       [2];
  logic       frame_done [2];

  always #5 clk = ~clk;

  sig_transmitter #(.CHIP_CLKS(CLK_A), .GAP_SYMBOLS(GAP_A)) dut_a (
    .clk(clk), .rst(rst[0]), .data_in(data_in[0]), .valid(valid[0]), .ready(ready[0]),
    .period_sel(period_sel[0]), .phase(phase[0]), .sig(sig[0]), .busy(busy[0]),
    .frame_done(frame_done[0])
  );

  sig_transmitter #(.CHIP_CLKS(CLK_B), .GAP_SYMBOLS(GAP_B)) dut_b (
    .clk(clk), .rst(rst[1]), .data_in(data_in[1]), .valid(valid[1]), .ready(ready[1]),
    .period_sel(period_sel[1]), .phase(phase[1]), .sig(sig[1]), .busy(busy[1]),
    .frame_done(frame_done[1])
  );

  typedef struct {
    logic s;
    logic d;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic logic base_chip(input logic psel, input int ph, input int k);
    int p;
    p = psel ? 8 : 6;
    return ((k + ph) % p) < (p / 2);
  endfunction

  task automatic push_frame(input int i, input logic [7:0] b, input logic psel, input int ph);
    int   p, gap, cc, nsym;
    logic bitv;
    exp_t e;
    p    = psel ? 8 : 6;
    gap  = (i == 0) ? GAP_A : GAP_B;
    cc   = (i == 0) ? CLK_A : CLK_B;
    nsym = 12 + gap;
    for (int s = 0; s < nsym; s++) begin
      bitv = (s < 4) ? 1'b1 : ((s < 12) ? b[s - 4] : 1'b0);
      for (int k = 0; k < p; k++) begin
        for (int c = 0; c < cc; c++) begin
          e.s = (s < 12) ? (bitv ? base_chip(psel, ph, k) : !base_chip(psel, ph, k)) : 1'b0;
          e.d = (s == nsym - 1) && (k == p - 1) && (c == cc - 1);
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic drain(input int i, input int n, input string tag);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_underflow"}, 8'd1, 8'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, "_sig"},  {7'd0, sig[i]},        {7'd0, e.s});
        chk({tag, "_busy"}, {7'd0, busy[i]},       8'd1);
        chk({tag, "_done"}, {7'd0, frame_done[i]}, {7'd0, e.d});
      end
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input int i, input string tag);
    chk({tag, "_idle_busy"},  {7'd0, busy[i]},       8'd0);
    chk({tag, "_idle_ready"}, {7'd0, ready[i]},      8'd1);
    chk({tag, "_idle_sig"},   {7'd0, sig[i]},        8'd0);
    chk({tag, "_idle_done"},  {7'd0, frame_done[i]}, 8'd0);
  endtask

  task automatic start(input int i, input logic [7:0] b, input logic psel, input logic [2:0] ph,
                       input string tag);
    valid[i]      = 1'b1;
    data_in[i]    = b;
    period_sel[i] = psel;
    phase[i]      = ph;
    chk({tag, "_ready"}, {7'd0, ready[i]}, 8'd1);
    push_frame(i, b, psel, int'(ph));
    @(negedge clk);
    valid[i]      = 1'b0;
    data_in[i]    = ~b;
    period_sel[i] = ~psel;
    phase[i]      = ph + 3'd3;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; data_in[i] = 8'h00; period_sel[i] = 1'b0; phase[i] = 3'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", {7'd0, ready[i]},      8'd0);
      chk("rst_busy",  {7'd0, busy[i]},       8'd0);
      chk("rst_sig",   {7'd0, sig[i]},        8'd0);
      chk("rst_done",  {7'd0, frame_done[i]}, 8'd0);
      rst[i] = 1'b0;
    end
    @(negedge clk);
    check_idle(0, "post_rst_a");
    check_idle(1, "post_rst_b");

    // Scenario 1: P=6, phase 0, 0xA5, one gap symbol (78 busy cycles)
    start(0, 8'hA5, 1'b0, 3'd0, "s1");
    drain(0, 78, "s1");
    check_idle(0, "s1");

    // Scenario 2: P=8, phase 2, 0xFF (104 busy cycles)
    start(0, 8'hFF, 1'b1, 3'd2, "s2");
    drain(0, 104, "s2");
    check_idle(0, "s2");

    // Scenario 3: P=6, phase 7 behaves as phase 1
    start(0, 8'h5A, 1'b0, 3'd7, "s3");
    drain(0, 78, "s3");
    check_idle(0, "s3");

    // Scenario 5: reset during data bit 3 aborts the frame
    start(0, 8'hA5, 1'b0, 3'd0, "s5");
    drain(0, 43, "s5");
    rst[0] = 1'b1;
    chk("s5_rst_done_now", {7'd0, frame_done[0]}, 8'd0);
    @(negedge clk);
    chk("s5_rst_sig",   {7'd0, sig[0]},        8'd0);
    chk("s5_rst_busy",  {7'd0, busy[0]},       8'd0);
    chk("s5_rst_done",  {7'd0, frame_done[0]}, 8'd0);
    chk("s5_rst_ready", {7'd0, ready[0]},      8'd0);
    rst[0] = 1'b0;
    sb.delete();
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      check_idle(0, "s5_after");
      @(negedge clk);
    end
    start(0, 8'h0F, 1'b1, 3'd3, "s5_fresh");
    drain(0, 104, "s5_fresh");
    check_idle(0, "s5_fresh");

    // Scenario 6: three clocks per chip, byte 0x00, no gap
    start(1, 8'h00, 1'b0, 3'd0, "s6");
    drain(1, 216, "s6");
    check_idle(1, "s6");

    // Scenario 4: valid held high across two back-to-back frames
    valid[1] = 1'b1; data_in[1] = 8'hA5; period_sel[1] = 1'b0; phase[1] = 3'd4;
    chk("s4_ready1", {7'd0, ready[1]}, 8'd1);
    push_frame(1, 8'hA5, 1'b0, 4);
    @(negedge clk);
    data_in[1] = 8'hC3; period_sel[1] = 1'b1; phase[1] = 3'd6;
    drain(1, 216, "s4_f1");
    chk("s4_gap_ready", {7'd0, ready[1]}, 8'd1);
    chk("s4_gap_busy",  {7'd0, busy[1]},  8'd0);
    chk("s4_gap_sig",   {7'd0, sig[1]},   8'd0);
    push_frame(1, 8'hC3, 1'b1, 6);
    @(negedge clk);
    valid[1] = 1'b0;
    drain(1, 288, "s4_f2");
    check_idle(1, "s4");
    chk("sb_empty", 8'(sb.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
